mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master arbiter for the SoC's native PicoRV32 memory bus (valid/ready, addr, wdata, wstrb, instr, rdata). It shares the single slave-side bus feeding the address decoder (SRAM, GPIO, UART, QSPI) between the CPU (master 0) and the loader/DMA engine (master 1). Arbitration is round-robin, and a grant is held for one whole transaction. An optional watchdog terminates transactions the slaves never acknowledge.

## Interface
- TIMEOUT_CYCLES, 255: watchdog limit in cycles, counted from grant start; legal range 1..65535.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out transaction.
- clk  in  1  bus clock; all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- m0_mem_valid / m1_mem_valid  in  1  master request.
- m0_mem_instr / m1_mem_instr  in  1  instruction-fetch flag.
- m0_mem_addr / m1_mem_addr  in  32  byte address.
- m0_mem_wdata / m1_mem_wdata  in  32  write data.
- m0_mem_wstrb / m1_mem_wstrb  in  4  byte strobes; 0 means read.
- m0_mem_ready / m1_mem_ready  out  1  transaction done for this master.
- m0_mem_rdata / m1_mem_rdata  out  32  read data.
- s_mem_valid, s_mem_instr, s_mem_addr[31:0], s_mem_wdata[31:0], s_mem_wstrb[3:0]  out  forwarded request.
- s_mem_ready  in  1  OR of slave readies.
- s_mem_rdata  in  32  OR-muxed slave read data.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- timeout_err  out  1  sticky timeout flag; present only with the macro below.

## Operation
- Masters hold valid and all request fields stable until they see ready. Masters never withdraw a request.
- The state machine has three states: IDLE, GNT0, GNT1. Reset state is IDLE.
- In IDLE, with only m0 valid, go to GNT0; with only m1 valid, go to GNT1.
- In IDLE with both valid, grant the master that is not `last`. `last` is a 1-bit register, reset to 1, so the CPU wins the first tie. `last` updates on every grant.
- In GNTx:
  - s_mem_* = mx_mem_* and s_mem_valid = mx_mem_valid.
  - mx_mem_ready = s_mem_ready.
  - mx_mem_rdata = s_mem_rdata.
  - When s_mem_ready=1, go to IDLE.
- The non-granted master sees ready=0 and rdata=0.
- In IDLE, s_mem_valid=0 and all s_mem_* are 0.
- grant is decoded from state: GNT0 gives 2'b01, GNT1 gives 2'b10.
- Reset values: every output is 0, state is IDLE, `last` is 1, and the timeout counter is 0.

## Timing
- Arbitration latency is 1 cycle. A request sampled in IDLE at edge t drives s_mem_valid from cycle t+1.
- Ready is combinational from s_mem_ready to the granted master's ready, with zero added latency.
- One mandatory IDLE bubble follows each completion, because the completing master's valid is still high in its ready cycle.
- With registered SRAM ready, a single master completes one access per 3 cycles.
- Under continuous contention, grants alternate strictly: m0, m1, m0, ...
- A master's valid rising in the same cycle as the other master's completion is evaluated in the following IDLE cycle. The fairness rule applies there.
- Asserting rst_n=0 during a transaction returns the block to IDLE immediately. All outputs drop asynchronously; no ready is issued for the aborted access.

## Configuration
- MEM_BUS_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to GNTx and increments each GNTx cycle while s_mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES−1 without s_mem_ready, the arbiter drives mx_mem_ready=1 and mx_mem_rdata=ERR_RDATA for one cycle and forces s_mem_valid=0 in that cycle.
  - It then goes to IDLE and sets timeout_err.
  - timeout_err clears only on reset.
  - If s_mem_ready arrives in the limit cycle, the normal completion wins: slave data is returned and no error is flagged.
- Macro undefined: no counter, the timeout_err port is absent, and grants hold indefinitely.

## Structure
- Package mem_bus_arb_pkg holds:
  - the state enum (IDLE, GNT0, GNT1);
  - the default ERR_RDATA constant;
  - the counter width (16).
- Sub-module mem_bus_arb_wdog holds the timeout counter and compare (inputs: start, busy, done; output: expire). It is instantiated only under MEM_BUS_ARB_TIMEOUT_EN.

## Test plan
- m0 reads 0x0000_0100 alone, slave answers with 1-cycle registered ready and rdata 0x1234_5678:
  - grant=01 from cycle t+1;
  - m0_mem_ready at t+2 with rdata 0x1234_5678;
  - grant=00 at t+3.
- m0 and m1 both valid from reset, each issuing 4 back-to-back accesses: grant order is 01, 10, 01, 10, …; neither master waits more than one transaction.
- m1 writes 0x0020_0000 with wstrb 4'b0011: s_mem_wstrb=0011, s_mem_addr=0x0020_0000 and s_mem_wdata match m1; m0 sees ready=0 throughout.
- Assert rst_n low mid-GNT1, before s_mem_ready: all outputs are 0 within the same cycle; after release, the first tie goes to m0.
- With MEM_BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the slave never asserts ready:
  - the master gets ready with rdata 0xDEAD_BEEF on the 8th granted cycle;
  - timeout_err=1 and stays 1 afterwards.
- With MEM_BUS_ARB_TIMEOUT_EN, s_mem_ready arrives in the limit cycle: slave data is returned and timeout_err stays 0.

Source files
------------

// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the two-master PicoRV32 memory bus arbiter.
// Holds the arbiter state encoding, default timeout read data and watchdog counter width.
package mem_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int          WDOG_CNT_W        = 16;

endpackage

// File: rtl/mem_bus_arb_wdog.sv
// Transaction watchdog: counts granted cycles without slave ready, flags the limit cycle.
// Latency: expire is combinational from the count; count clears on start, steps while busy and not done.
// Backpressure: none; done in the limit cycle suppresses expire so normal completion wins.
module mem_bus_arb_wdog
    import mem_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic busy,
    input  logic done,
    output logic expire
);

    localparam logic [WDOG_CNT_W-1:0] LIMIT = WDOG_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (busy && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = busy && !done && (cnt == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-master arbiter for the PicoRV32 native bus; optional watchdog via MEM_BUS_ARB_TIMEOUT_EN.
// Latency: 1 cycle request-to-grant; ready/rdata pass through combinationally; one IDLE bubble per access.
// Backpressure: grant held until s_mem_ready (or watchdog expiry); the loser sees ready=0, rdata=0.
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,
    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,
    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,
    output logic [1:0]  grant
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES out of range 1..65535");
    end

    arb_state_t state;
    logic       last;
    logic       expire;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    logic wdog_start;
    logic wdog_busy;

    assign wdog_start = (state == IDLE) && (m0_mem_valid || m1_mem_valid);
    assign wdog_busy  = (state != IDLE);

    mem_bus_arb_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .start (wdog_start),
        .busy  (wdog_busy),
        .done  (s_mem_ready),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (expire) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    // last holds the most recently granted master; a tie goes to the other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            grant <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_mem_valid && (!m1_mem_valid || last)) begin
                        state <= GNT0;
                        last  <= 1'b0;
                        grant <= 2'b01;
                    end else if (m1_mem_valid) begin
                        state <= GNT1;
                        last  <= 1'b1;
                        grant <= 2'b10;
                    end
                end
                GNT0, GNT1: begin
                    if (s_mem_ready || expire) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        s_mem_valid  = 1'b0;
        s_mem_instr  = 1'b0;
        s_mem_addr   = '0;
        s_mem_wdata  = '0;
        s_mem_wstrb  = '0;
        m0_mem_ready = 1'b0;
        m0_mem_rdata = '0;
        m1_mem_ready = 1'b0;
        m1_mem_rdata = '0;
        case (state)
            GNT0: begin
                s_mem_valid  = m0_mem_valid && !expire;
                s_mem_instr  = m0_mem_instr;
                s_mem_addr   = m0_mem_addr;
                s_mem_wdata  = m0_mem_wdata;
                s_mem_wstrb  = m0_mem_wstrb;
                m0_mem_ready = s_mem_ready || expire;
                m0_mem_rdata = expire ? ERR_RDATA : s_mem_rdata;
            end
            GNT1: begin
                s_mem_valid  = m1_mem_valid && !expire;
                s_mem_instr  = m1_mem_instr;
                s_mem_addr   = m1_mem_addr;
                s_mem_wdata  = m1_mem_wdata;
                s_mem_wstrb  = m1_mem_wstrb;
                m1_mem_ready = s_mem_ready || expire;
                m1_mem_rdata = expire ? ERR_RDATA : s_mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: scripted masters, a latency-programmable slave and a
// completion scoreboard; the timeout scenarios run only when MEM_BUS_ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_mem_valid = 1'b0, m0_mem_instr = 1'b0;
    logic [31:0] m0_mem_addr = '0, m0_mem_wdata = '0;
    logic [3:0]  m0_mem_wstrb = '0;
    logic        m0_mem_ready;
    logic [31:0] m0_mem_rdata;
    logic        m1_mem_valid = 1'b0, m1_mem_instr = 1'b0;
    logic [31:0] m1_mem_addr = '0, m1_mem_wdata = '0;
    logic [3:0]  m1_mem_wstrb = '0;
    logic        m1_mem_ready;
    logic [31:0] m1_mem_rdata;
    logic        s_mem_valid, s_mem_instr;
    logic [31:0] s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_wstrb;
    logic        s_mem_ready = 1'b0;
    logic [31:0] s_mem_rdata = '0;
    logic [1:0]  grant;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_addr(m0_mem_addr),
        .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb),
        .m0_mem_ready(m0_mem_ready), .m0_mem_rdata(m0_mem_rdata),
        .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_addr(m1_mem_addr),
        .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb),
        .m1_mem_ready(m1_mem_ready), .m1_mem_rdata(m1_mem_rdata),
        .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr), .s_mem_addr(s_mem_addr),
        .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb),
        .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata),
        .grant(grant)
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  wstrb;
        logic        instr;
    } req_t;

    req_t       q0[$];
    req_t       q1[$];
    logic [1:0] obs[$];
    int         errors = 0;
    int         checks = 0;
    int         slave_lat = 1;
    int         wcnt = 0;
    logic       pend = 1'b0;
    int         cyc = 0;
    int         rdy_cyc0 = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h1234_5678 : (a ^ 32'hA5A5_0F0F);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave: ready slave_lat cycles after it first sees valid, registered off the clock edge.
    initial forever begin
        @(negedge clk);
        if (s_mem_valid && !s_mem_ready) begin
            wcnt++;
            pend = (wcnt >= slave_lat);
        end else begin
            wcnt = 0;
            pend = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        s_mem_ready = pend;
        s_mem_rdata = pend ? slave_data(s_mem_addr) : 32'h0;
    end

    task automatic on_ready(input int m);
        req_t        e;
        logic [31:0] rd;
        logic        oth;
        logic [1:0]  g;
        g   = (m == 0) ? 2'b01 : 2'b10;
        rd  = (m == 0) ? m0_mem_rdata : m1_mem_rdata;
        oth = (m == 0) ? m1_mem_ready : m0_mem_ready;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            check("spurious_ready", 32'((m == 0) ? m0_mem_ready : m1_mem_ready), 32'h0);
            return;
        end
        if (m == 0) begin
            e = q0.pop_front();
            rdy_cyc0 = cyc;
        end else begin
            e = q1.pop_front();
        end
        check("grant_at_ready", 32'(grant), 32'(g));
        check("rdata", rd, e.rdata);
        check("other_ready", 32'(oth), 32'h0);
        if (s_mem_ready) begin
            check("s_valid", 32'(s_mem_valid), 32'h1);
            check("s_addr", s_mem_addr, e.addr);
            check("s_wdata", s_mem_wdata, e.wdata);
            check("s_wstrb", 32'(s_mem_wstrb), 32'(e.wstrb));
            check("s_instr", 32'(s_mem_instr), 32'(e.instr));
        end
        obs.push_back(grant);
    endtask

    initial forever begin
        @(negedge clk);
        if (m0_mem_ready) on_ready(0);
        if (m1_mem_ready) on_ready(1);
    end

    // Call at posedge+#1; returns at posedge+#1 after this master's ready cycle.
    task automatic issue(input int m, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic ins, input logic [31:0] exp_rd);
        req_t e;
        int   n;
        logic r;
        e = '{addr: a, wdata: wd, rdata: exp_rd, wstrb: ws, instr: ins};
        if (m == 0) begin
            q0.push_back(e);
            m0_mem_valid = 1'b1; m0_mem_addr = a; m0_mem_wdata = wd;
            m0_mem_wstrb = ws; m0_mem_instr = ins;
        end else begin
            q1.push_back(e);
            m1_mem_valid = 1'b1; m1_mem_addr = a; m1_mem_wdata = wd;
            m1_mem_wstrb = ws; m1_mem_instr = ins;
        end
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            r = (m == 0) ? m0_mem_ready : m1_mem_ready;
            if (r) break;
            if (n > 200) begin
                check("ready_wait_bound", 32'(r), 32'h1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (m == 0) m0_mem_valid = 1'b0;
        else        m1_mem_valid = 1'b0;
    endtask

    task automatic do_reset();
        m0_mem_valid = 1'b0;
        m1_mem_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_s_valid"}, 32'(s_mem_valid), 32'h0);
        check({tag, "_s_addr"}, s_mem_addr, 32'h0);
        check({tag, "_s_wdata"}, s_mem_wdata, 32'h0);
        check({tag, "_s_wstrb_instr"}, {27'd0, s_mem_wstrb, s_mem_instr}, 32'h0);
        check({tag, "_readies"}, {30'd0, m0_mem_ready, m1_mem_ready}, 32'h0);
        check({tag, "_m0_rdata"}, m0_mem_rdata, 32'h0);
        check({tag, "_m1_rdata"}, m1_mem_rdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int t1;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single m0 read with registered-ready slave
        @(posedge clk);
        #1;
        q0.push_back('{addr: 32'h100, wdata: 32'h0, rdata: 32'h1234_5678, wstrb: 4'h0, instr: 1'b0});
        m0_mem_valid = 1'b1; m0_mem_addr = 32'h100; m0_mem_wdata = 32'h0;
        m0_mem_wstrb = 4'h0; m0_mem_instr = 1'b0;
        @(negedge clk);
        check("t1_grant_before", 32'(grant), 32'h0);
        @(negedge clk);
        check("t1_grant_t1", 32'(grant), 32'h1);
        check("t1_s_valid_t1", 32'(s_mem_valid), 32'h1);
        check("t1_s_addr_t1", s_mem_addr, 32'h100);
        check("t1_ready_t1", 32'(m0_mem_ready), 32'h0);
        @(negedge clk);
        check("t1_ready_t2", 32'(m0_mem_ready), 32'h1);
        check("t1_rdata_t2", m0_mem_rdata, 32'h1234_5678);
        @(posedge clk);
        #1;
        m0_mem_valid = 1'b0;
        @(negedge clk);
        check("t1_grant_t3", 32'(grant), 32'h0);

        // Single-master throughput: one access every 3 cycles
        @(posedge clk);
        #1;
        issue(0, 32'h0000_0200, 32'h0, 4'h0, 1'b1, slave_data(32'h0000_0200));
        t1 = rdy_cyc0;
        issue(0, 32'h0000_0204, 32'h0, 4'h0, 1'b1, slave_data(32'h0000_0204));
        check("throughput_cycles", 32'(rdy_cyc0 - t1), 32'd3);

        // Contention from reset: strict alternation starting with m0
        do_reset();
        obs.delete();
        fork
            begin
                for (int i = 0; i < 4; i++)
                    issue(0, 32'h0000_1000 + 32'(i * 4), 32'h0, 4'h0, 1'b0,
                          slave_data(32'h0000_1000 + 32'(i * 4)));
            end
            begin
                for (int j = 0; j < 4; j++)
                    issue(1, 32'h0000_2000 + 32'(j * 4), 32'h5000_0000 + 32'(j), 4'hF, 1'b0,
                          slave_data(32'h0000_2000 + 32'(j * 4)));
            end
        join
        check("contend_count", 32'(obs.size()), 32'd8);
        for (int k = 0; k < obs.size(); k++)
            check("contend_order", 32'(obs[k]), (k % 2 == 0) ? 32'h1 : 32'h2);

        // m1 partial write; m0 stays quiet
        @(posedge clk);
        #1;
        fork
            issue(1, 32'h0020_0000, 32'hCAFE_F00D, 4'b0011, 1'b0, slave_data(32'h0020_0000));
            begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check("wr_m0_ready", 32'(m0_mem_ready), 32'h0);
                    check("wr_m0_rdata", m0_mem_rdata, 32'h0);
                    if (c == 1) check("wr_s_wstrb", 32'(s_mem_wstrb), 32'h3);
                end
            end
        join

        // Reset mid-GNT1, then first tie goes to m0
        @(posedge clk);
        #1;
        slave_lat = 1000;
        m1_mem_valid = 1'b1; m1_mem_addr = 32'h0000_3000; m1_mem_wdata = 32'h0;
        m1_mem_wstrb = 4'h0; m1_mem_instr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_grant", 32'(grant), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        m1_mem_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        slave_lat = 1;
        obs.delete();
        fork
            issue(0, 32'h0000_4000, 32'h0, 4'h0, 1'b0, slave_data(32'h0000_4000));
            issue(1, 32'h0000_5000, 32'h0, 4'h0, 1'b0, slave_data(32'h0000_5000));
        join
        check("tie_after_reset_count", 32'(obs.size()), 32'd2);
        check("tie_after_reset_first", 32'(obs[0]), 32'h1);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
        // Slave ready lands in the limit cycle: normal completion wins
        do_reset();
        slave_lat = TO - 1;
        fork
            issue(0, 32'h0000_0300, 32'h0, 4'h0, 1'b0, slave_data(32'h0000_0300));
            begin
                int n;
                n = 0;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (grant != 2'b00) n++;
                    if (m0_mem_ready) break;
                end
                check("limit_granted_cycles", 32'(n), 32'(TO));
            end
        join
        check("limit_no_err", 32'(timeout_err), 32'h0);

        // Slave never answers: error data on the TO-th granted cycle
        slave_lat = 1000;
        fork
            issue(1, 32'h0000_0400, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);
            begin
                int n;
                n = 0;
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    if (grant != 2'b00) n++;
                    if (m1_mem_ready) begin
                        check("to_s_valid_forced", 32'(s_mem_valid), 32'h0);
                        check("to_err_before", 32'(timeout_err), 32'h0);
                        break;
                    end
                end
                check("to_granted_cycles", 32'(n), 32'(TO));
            end
        join
        @(negedge clk);
        check("to_err_set", 32'(timeout_err), 32'h1);
        slave_lat = 1;
        @(posedge clk);
        #1;
        issue(0, 32'h0000_0500, 32'h0, 4'h0, 1'b0, slave_data(32'h0000_0500));
        check("to_err_sticky", 32'(timeout_err), 32'h1);
`endif

        repeat (3) @(negedge clk);
        check("final_q0_empty", 32'(q0.size()), 32'h0);
        check("final_q1_empty", 32'(q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
